// File: rtl/decode_ctrl_pkg.sv
// Shared constants for the decode-stage interlock: opcodes, ALU ops, FSM encodings.
package decode_ctrl_pkg;
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_WAIT = 2'd1;
endpackage

// File: rtl/hazard_detect.sv
// Combinational decode classification and load-use hazard detection.
module hazard_detect
    import decode_ctrl_pkg::*;
(
    input  logic       i_dec_valid,
    input  logic [4:0] i_opcode,
    input  logic [4:0] i_aluop,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_ex_lw,
    input  logic [4:0] i_ex_rd,
    output logic       o_uses_rs,
    output logic       o_uses_rt,
    output logic       o_md_op,
    output logic       o_lu
);
    logic w_rtype;

    assign w_rtype   = (i_opcode == OP_RTYPE);
    assign o_md_op   = w_rtype && ((i_aluop == ALU_MUL) || (i_aluop == ALU_DIV));
    assign o_uses_rs = !((i_opcode == OP_J) || (i_opcode == OP_JAL) || (i_opcode == OP_BEX));
    assign o_uses_rt = w_rtype || (i_opcode == OP_SW) || (i_opcode == OP_BNE) ||
                       (i_opcode == OP_BLT);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_lu = i_dec_valid && i_ex_lw && (i_ex_rd != 5'd0) &&
                  ((o_uses_rs && (i_rs == i_ex_rd)) || (o_uses_rt && (i_rt == i_ex_rd)));
endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage interlock FSM: load-use stall, mult/div hold with timeout, branch squash.
// Optional HAZARD_STATS_EN adds saturating lu_stalls / md_stalls counters.
module decode_hazard_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic [4:0] dec_opcode,
    input  logic [4:0] dec_aluop,
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    input  logic       ex_lw,
    input  logic [4:0] ex_rd,
    input  logic       br_taken,
    input  logic       md_ready,
    output logic       stall_fd,
    output logic       bubble_dx,
    output logic       flush,
    output logic       md_start,
    output logic       md_error,
    output logic [1:0] state
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] lu_stalls,
    output logic [CNT_W-1:0] md_stalls
`endif
);
    localparam int WC_W = $clog2(MD_TIMEOUT) + 1;

    logic [1:0]      r_state;
    logic [WC_W-1:0] r_cnt;
    logic [1:0]      w_next;
    logic [WC_W-1:0] w_cnt_nxt;
    logic            w_uses_rs, w_uses_rt, w_md_op, w_lu;
    logic            w_stall, w_bubble, w_flush, w_start, w_error;
    logic            w_lu_stall, w_md_stall;

    hazard_detect u_hazard_detect (
        .i_dec_valid (dec_valid),
        .i_opcode    (dec_opcode),
        .i_aluop     (dec_aluop),
        .i_rs        (dec_rs),
        .i_rt        (dec_rt),
        .i_ex_lw     (ex_lw),
        .i_ex_rd     (ex_rd),
        .o_uses_rs   (w_uses_rs),
        .o_uses_rt   (w_uses_rt),
        .o_md_op     (w_md_op),
        .o_lu        (w_lu)
    );

    always_comb begin
        w_stall    = 1'b0;
        w_bubble   = 1'b0;
        w_flush    = 1'b0;
        w_start    = 1'b0;
        w_error    = 1'b0;
        w_lu_stall = 1'b0;
        w_md_stall = 1'b0;
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (br_taken) begin
                    w_flush = 1'b1;
                end else if (w_lu) begin
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                    w_lu_stall = 1'b1;
                end else if (dec_valid && w_md_op) begin
                    w_start    = 1'b1;
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                    w_md_stall = 1'b1;
                    w_cnt_nxt  = '0;
                    w_next     = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                // br_taken here is a protocol violation; squash and drop the op
                if (br_taken) begin
                    w_flush = 1'b1;
                    w_next  = ST_RUN;
                end else if (md_ready) begin
                    w_next = ST_RUN;
                end else if (r_cnt == WC_W'(MD_TIMEOUT - 1)) begin
                    w_error = 1'b1;
                    w_next  = ST_RUN;
                end else begin
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                    w_md_stall = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
            end
            default: w_next = ST_RUN;
        endcase
    end

    // Outputs are held quiet while reset is asserted, whatever the inputs do
    assign stall_fd  = w_stall  && !reset;
    assign bubble_dx = w_bubble && !reset;
    assign flush     = w_flush  && !reset;
    assign md_start  = w_start  && !reset;
    assign md_error  = w_error  && !reset;
    assign state     = r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_lu_stalls, r_md_stalls;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lu_stalls <= '0;
            r_md_stalls <= '0;
        end else begin
            if (w_lu_stall && (r_lu_stalls != '1)) r_lu_stalls <= r_lu_stalls + 1'b1;
            if (w_md_stall && (r_md_stalls != '1)) r_md_stalls <= r_md_stalls + 1'b1;
        end
    end

    assign lu_stalls = r_lu_stalls;
    assign md_stalls = r_md_stalls;
`endif
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed self-checking bench for decode_hazard_ctrl (MD_TIMEOUT=8, CNT_W=2).
module tb_decode_hazard_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_opcode, dec_aluop, dec_rs, dec_rt, ex_rd;
    logic       ex_lw, br_taken, md_ready;
    logic       stall_fd, bubble_dx, flush, md_start, md_error;
    logic [1:0] state;
`ifdef HAZARD_STATS_EN
    logic [1:0] lu_stalls, md_stalls;
`endif
    logic [4:0] o;
    int         n_chk = 0;
    int         n_fail = 0;

    // o = {stall_fd, bubble_dx, flush, md_start, md_error}
    assign o = {stall_fd, bubble_dx, flush, md_start, md_error};

    always #5 clock = ~clock;

    decode_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_aluop(dec_aluop), .dec_rs(dec_rs), .dec_rt(dec_rt), .ex_lw(ex_lw),
        .ex_rd(ex_rd), .br_taken(br_taken), .md_ready(md_ready), .stall_fd(stall_fd),
        .bubble_dx(bubble_dx), .flush(flush), .md_start(md_start), .md_error(md_error),
        .state(state)
`ifdef HAZARD_STATS_EN
        , .lu_stalls(lu_stalls), .md_stalls(md_stalls)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        dec_valid = 0; dec_opcode = 0; dec_aluop = 0; dec_rs = 0; dec_rt = 0;
        ex_lw = 0; ex_rd = 0; br_taken = 0; md_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic set_dec(input logic [4:0] op, input logic [4:0] alu,
                           input logic [4:0] rs, input logic [4:0] rt);
        dec_valid = 1; dec_opcode = op; dec_aluop = alu; dec_rs = rs; dec_rt = rt;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        set_dec(5'b00000, 5'b00110, 5'd5, 5'd0);
        ex_lw = 1; ex_rd = 5; br_taken = 1; md_ready = 1;
        tick(); #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL reset_outs: got %b want 00000", o); end
        n_chk++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        idle();
        tick();
        reset = 0;
        #1;
        n_chk++;
        if (o !== 5'b00000 || state !== 2'd0) begin
            n_fail++; $display("FAIL post_reset: got %b st %0d want 00000 st 0", o, state);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_lw = 1; ex_rd = 5;
        set_dec(5'b00000, 5'b00000, 5'd5, 5'd2);
        #1;
        n_chk++;
        if (o !== 5'b11000) begin n_fail++; $display("FAIL lu_rs: got %b want 11000", o); end
        tick();
        ex_lw = 0; ex_rd = 0;   // lw moved on, bubble now in execute
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL lu_clear: got %b want 00000", o); end
        tick();
        ex_lw = 1; ex_rd = 0; set_dec(5'b00000, 5'b00000, 5'd0, 5'd0);
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL lu_r0: got %b want 00000", o); end
        tick();
        ex_rd = 9; set_dec(5'b00111, 5'b00000, 5'd3, 5'd9);   // sw rt match
        #1;
        n_chk++;
        if (o !== 5'b11000) begin n_fail++; $display("FAIL lu_sw_rt: got %b want 11000", o); end
        tick();
        set_dec(5'b01000, 5'b00000, 5'd3, 5'd9);              // lw does not read rt
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL lu_lw_rt: got %b want 00000", o); end
        tick();
        set_dec(5'b00000, 5'b00000, 5'd9, 5'd9);
        dec_valid = 0;
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL lu_nop: got %b want 00000", o); end
        tick();
        idle();
    endtask

    task automatic test_no_false();
        idle();
        ex_lw = 1; ex_rd = 7;
        set_dec(5'b00001, 5'b00000, 5'd7, 5'd7);   // j
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL nf_j: got %b want 00000", o); end
        tick();
        set_dec(5'b10110, 5'b00000, 5'd7, 5'd7);   // bex
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL nf_bex: got %b want 00000", o); end
        tick();
        idle();
    endtask

    task automatic test_mult();
        int stalls;
        idle();
        stalls = 0;
        set_dec(5'b00000, 5'b00110, 5'd1, 5'd2);
        #1;
        n_chk++;
        if (o !== 5'b11010 || state !== 2'd0) begin
            n_fail++; $display("FAIL mul_start: got %b st %0d want 11010 st 0", o, state);
        end
        if (stall_fd) stalls++;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            if (stall_fd) stalls++;
            n_chk++;
            if (o !== 5'b11000 || state !== 2'd1) begin
                n_fail++; $display("FAIL mul_wait%0d: got %b st %0d want 11000 st 1", i, o, state);
            end
        end
        tick();
        md_ready = 1;
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL mul_ready: got %b want 00000", o); end
        n_chk++;
        if (stalls !== 6) begin n_fail++; $display("FAIL mul_stall_cnt: got %0d want 6", stalls); end
        tick();
        idle();
        #1;
        n_chk++;
        if (o !== 5'b00000 || state !== 2'd0) begin
            n_fail++; $display("FAIL mul_done: got %b st %0d want 00000 st 0", o, state);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        set_dec(5'b00000, 5'b00110, 5'd1, 5'd2);
        tick(); tick();
        md_ready = 1;
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL b2b_ready: got %b want 00000", o); end
        tick();
        md_ready = 0;
        set_dec(5'b00000, 5'b00111, 5'd3, 5'd4);   // div right behind
        #1;
        n_chk++;
        if (o !== 5'b11010 || state !== 2'd0) begin
            n_fail++; $display("FAIL b2b_start2: got %b st %0d want 11010 st 0", o, state);
        end
        tick(); #1;
        n_chk++;
        if (md_start !== 1'b0 || state !== 2'd1) begin
            n_fail++; $display("FAIL b2b_no_repeat: got start %b st %0d want 0 st 1", md_start, state);
        end
        md_ready = 1;
        tick();
        idle();
    endtask

    task automatic test_branch_priority();
        idle();
        ex_lw = 1; ex_rd = 5; br_taken = 1;
        set_dec(5'b00000, 5'b00000, 5'd5, 5'd5);
        #1;
        n_chk++;
        if (o !== 5'b00100) begin n_fail++; $display("FAIL br_over_lu: got %b want 00100", o); end
        tick();
        idle();
        set_dec(5'b00000, 5'b00110, 5'd1, 5'd1);
        tick();
        br_taken = 1; md_ready = 1;
        #1;
        n_chk++;
        if (o !== 5'b00100 || state !== 2'd1) begin
            n_fail++; $display("FAIL br_in_wait: got %b st %0d want 00100 st 1", o, state);
        end
        tick();
        idle();
        md_ready = 1;   // late ready must be ignored
        #1;
        n_chk++;
        if (o !== 5'b00000 || state !== 2'd0) begin
            n_fail++; $display("FAIL br_late_ready: got %b st %0d want 00000 st 0", o, state);
        end
        tick();
        idle();
    endtask

    task automatic test_timeout();
        idle();
        set_dec(5'b00000, 5'b00111, 5'd1, 5'd1);
        tick();
        for (int i = 1; i <= 7; i++) begin
            #1;
            n_chk++;
            if (o !== 5'b11000) begin n_fail++; $display("FAIL to_wait%0d: got %b want 11000", i, o); end
            tick();
        end
        #1;
        n_chk++;
        if (o !== 5'b00001 || state !== 2'd1) begin
            n_fail++; $display("FAIL to_error: got %b st %0d want 00001 st 1", o, state);
        end
        idle();
        tick(); #1;
        n_chk++;
        if (o !== 5'b00000 || state !== 2'd0) begin
            n_fail++; $display("FAIL to_back_run: got %b st %0d want 00000 st 0", o, state);
        end
        set_dec(5'b00000, 5'b00110, 5'd1, 5'd1);
        tick();
        for (int i = 1; i <= 7; i++) tick();
        md_ready = 1;   // ready beats timeout on the 8th wait cycle
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL to_ready_wins: got %b want 00000", o); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_wait();
        logic seen_err;
        idle();
        seen_err = 0;
        set_dec(5'b00000, 5'b00110, 5'd1, 5'd1);
        tick(); tick(); tick();
        reset = 1; md_ready = 1;
        #1;
        n_chk++;
        if (o !== 5'b00000) begin n_fail++; $display("FAIL rmw_during: got %b want 00000", o); end
        tick();
        reset = 0;
        dec_valid = 0;
        #1;
        n_chk++;
        if (o !== 5'b00000 || state !== 2'd0) begin
            n_fail++; $display("FAIL rmw_after: got %b st %0d want 00000 st 0", o, state);
        end
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            if (md_error) seen_err = 1;
        end
        n_chk++;
        if (seen_err !== 1'b0) begin n_fail++; $display("FAIL rmw_no_err: got %b want 0", seen_err); end
        idle();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        n_chk++;
        if (lu_stalls !== 2'd0 || md_stalls !== 2'd0) begin
            n_fail++; $display("FAIL st_reset: got %0d/%0d want 0/0", lu_stalls, md_stalls);
        end
        ex_lw = 1; ex_rd = 4;
        set_dec(5'b00000, 5'b00000, 5'd4, 5'd0);
        tick(); tick();
        #1;
        n_chk++;
        if (lu_stalls !== 2'd2) begin n_fail++; $display("FAIL st_lu2: got %0d want 2", lu_stalls); end
        tick(); tick(); tick();
        #1;
        n_chk++;
        if (lu_stalls !== 2'd3) begin n_fail++; $display("FAIL st_lu_sat: got %0d want 3", lu_stalls); end
        idle();
        set_dec(5'b00000, 5'b00110, 5'd1, 5'd1);
        tick(); tick(); tick(); tick();
        md_ready = 1;
        tick();
        idle();
        #1;
        n_chk++;
        if (md_stalls !== 2'd3 || lu_stalls !== 2'd3) begin
            n_fail++; $display("FAIL st_md_sat: got %0d/%0d want 3/3", md_stalls, lu_stalls);
        end
    endtask
`endif

    initial begin
        idle();
        reset = 1;
        #2;
        test_reset();
        test_load_use();
        test_no_false();
        test_mult();
        test_back_to_back();
        test_branch_priority();
        test_timeout();
        test_reset_mid_wait();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
